stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_pkg.sv | 22 ++
 rtl/rr_priority_select.sv | 37 +++
 rtl/stream_rr_arbiter.sv | 116 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types, default sizing and width helpers for the round-robin stream arbiter.
package stream_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_DEFAULT     = 4;
  localparam int unsigned BURST_DEFAULT = 16;
  localparam int unsigned DW_DEFAULT    = 32;

  // Burst counter must hold BURST-1; one extra bit keeps BURST=1 at a legal width.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: first set mask bit after LAST, wrapping around.
module rr_priority_select
  import stream_rr_arbiter_pkg::*;
#(
  parameter  int unsigned N  = N_DEFAULT,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] index_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    start;
  int unsigned    first;
  logic           found;

  // Rotate so the bit after LAST sits at position 0, pick the lowest set bit, rotate back.
  always_comb begin
    start = (32'(last_i) + 32'd1) % N;
    dbl   = {mask_i, mask_i};
    rot   = N'(dbl >> start);
    first = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        first = k;
      end
    end
    valid_o = found;
    index_o = IW'((start + first) % N);
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter moving words from N FWFT sources into one downstream FIFO,
// with per-grant burst limit and a one-cycle idle bubble between grants.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned BURST = BURST_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST,
  input  logic [N-1:0]    ENABLE,
  input  logic [N-1:0]    REQ,
  input  logic [N*DW-1:0] DATA_IN,
  output logic [N-1:0]    READ,
  input  logic            READY_IN,
  output logic            WRITE_OUT,
  output logic [DW-1:0]   DATA_OUT,
  output logic [N-1:0]    GRANT_OUT,
  output logic            BUSY,
  output logic [31:0]     TRANSFER_CNT
);

  localparam int unsigned IW = idx_width(N);
  localparam int unsigned CW = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   tcnt_q, tcnt_d;

  logic [IW-1:0] sel_idx;
  logic          sel_valid;
  logic          src_live;
  logic          xfer;
  logic          release_c;

  rr_priority_select #(.N(N)) u_sel (
    .mask_i  (REQ & ENABLE),
    .last_i  (last_q),
    .index_o (sel_idx),
    .valid_o (sel_valid)
  );

  assign src_live     = (state_q == ST_GRANT) && REQ[g_q] && ENABLE[g_q];
  assign xfer         = src_live && READY_IN && !BUS_RST;
  assign release_c    = !REQ[g_q] || !ENABLE[g_q] || (xfer && (cnt_q == CNT_LAST));
  assign TRANSFER_CNT = tcnt_q;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d = ST_GRANT;
          g_d     = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          cnt_d  = cnt_q + 1'b1;
          tcnt_d = tcnt_q + 32'd1;
        end
        // A release on the burst's last word still counts that word above.
        if (release_c) begin
          state_d = ST_IDLE;
          last_d  = g_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    READ      = '0;
    WRITE_OUT = 1'b0;
    DATA_OUT  = '0;
    GRANT_OUT = '0;
    BUSY      = 1'b0;
    if (!BUS_RST && (state_q == ST_GRANT)) begin
      BUSY           = 1'b1;
      GRANT_OUT[g_q] = 1'b1;
      WRITE_OUT      = src_live;
      READ[g_q]      = xfer;
      if (src_live) begin
        DATA_OUT = DATA_IN[32'(g_q) * DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter with a per-cycle behavioural reference model.
module tb_stream_rr_arbiter;

  localparam int N     = 4;
  localparam int BURST = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            BUS_RST;
  logic [N-1:0]    ENABLE;
  logic [N-1:0]    REQ;
  logic [N*DW-1:0] DATA_IN;
  logic [N-1:0]    READ;
  logic            READY_IN;
  logic            WRITE_OUT;
  logic [DW-1:0]   DATA_OUT;
  logic [N-1:0]    GRANT_OUT;
  logic            BUSY;
  logic [31:0]     TRANSFER_CNT;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.N(N), .BURST(BURST), .DW(DW)) dut (
    .BUS_CLK      (clk),
    .BUS_RST      (BUS_RST),
    .ENABLE       (ENABLE),
    .REQ          (REQ),
    .DATA_IN      (DATA_IN),
    .READ         (READ),
    .READY_IN     (READY_IN),
    .WRITE_OUT    (WRITE_OUT),
    .DATA_OUT     (DATA_OUT),
    .GRANT_OUT    (GRANT_OUT),
    .BUSY         (BUSY),
    .TRANSFER_CNT (TRANSFER_CNT)
  );

  // Source FIFOs (first-word-fall-through)
  logic [DW-1:0] mem [N][DEPTH];
  int head [N];
  int tail [N];
  int popped [N];

  logic [N-1:0] en_v;
  logic         rdy_v;
  logic         rst_v;

  // Reference model: owner = -1 when nobody holds the bus
  int          m_owner;
  int          m_last;
  int          m_words;
  logic [31:0] m_tcnt;
  int          log_src [32];
  int          log_words [32];
  int          log_n;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic has(input int s);
    return head[s] < tail[s];
  endfunction

  task automatic load(input int s, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (tail[s] < DEPTH) begin
        mem[s][tail[s]] = 32'hA000_0000 | (32'(s) << 16) | 32'(tail[s]);
        tail[s]++;
      end
    end
  endtask

  task automatic flush();
    for (int s = 0; s < N; s++) begin
      head[s]   = 0;
      tail[s]   = 0;
      popped[s] = 0;
    end
  endtask

  task automatic drive();
    for (int s = 0; s < N; s++) begin
      REQ[s] = has(s);
      DATA_IN[s*DW +: DW] = has(s) ? mem[s][head[s]] : (32'hDEAD_0000 | 32'(s));
    end
    ENABLE   = en_v;
    READY_IN = rdy_v;
    BUS_RST  = rst_v;
  endtask

  task automatic check();
    logic [N-1:0]  e_rd;
    logic [N-1:0]  e_gnt;
    logic          e_wr;
    logic          e_busy;
    logic [DW-1:0] e_data;
    logic          xfer;
    logic          found;
    int            o;
    int            s;
    e_rd   = '0;
    e_gnt  = '0;
    e_wr   = 1'b0;
    e_busy = 1'b0;
    e_data = '0;
    o      = m_owner;
    if (!rst_v && o >= 0) begin
      e_busy   = 1'b1;
      e_gnt[o] = 1'b1;
      e_wr     = has(o) && en_v[o];
      if (e_wr) begin
        e_data = mem[o][head[o]];
        if (rdy_v) e_rd[o] = 1'b1;
      end
    end
    chk("WRITE_OUT", 64'(WRITE_OUT), 64'(e_wr));
    chk("READ", 64'(READ), 64'(e_rd));
    chk("GRANT_OUT", 64'(GRANT_OUT), 64'(e_gnt));
    chk("DATA_OUT", 64'(DATA_OUT), 64'(e_data));
    chk("BUSY", 64'(BUSY), 64'(e_busy));
    chk("TRANSFER_CNT", 64'(TRANSFER_CNT), 64'(m_tcnt));

    xfer = e_wr && rdy_v;
    if (rst_v) begin
      m_owner = -1;
      m_last  = N - 1;
      m_words = 0;
      m_tcnt  = '0;
    end else if (o < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        s = (m_last + k) % N;
        if (!found && has(s) && en_v[s]) begin
          found   = 1'b1;
          m_owner = s;
          m_words = 0;
        end
      end
    end else begin
      if (xfer) begin
        m_words++;
        m_tcnt = m_tcnt + 32'd1;
      end
      if ((xfer && m_words == BURST) || !e_wr) begin
        if (log_n < 32) begin
          log_src[log_n]   = o;
          log_words[log_n] = m_words;
          log_n++;
        end
        m_last  = o;
        m_owner = -1;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (READ[i] && has(i)) begin
        head[i]++;
        popped[i]++;
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    flush();
    cycle();
    rst_v = 1'b0;
    log_n = 0;
  endtask

  task automatic chk_log(input string tag, input int idx, input int es, input int ew);
    if (idx < log_n) begin
      chk({tag, "_src"}, 64'(log_src[idx]), 64'(es));
      chk({tag, "_words"}, 64'(log_words[idx]), 64'(ew));
    end else begin
      chk({tag, "_missing"}, 64'(log_n), 64'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp35_s [8];
    int exp35_w [8];
    int w;
    exp35_s = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp35_w = '{16, 16, 16, 16, 4, 4, 4, 4};
    en_v    = '1;
    rdy_v   = 1'b1;
    rst_v   = 1'b1;
    m_owner = -1;
    m_last  = N - 1;
    m_words = 0;
    m_tcnt  = '0;
    log_n   = 0;
    flush();
    drive();
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("rst_grant", 64'(GRANT_OUT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_tcnt", 64'(TRANSFER_CNT), 64'd0);
    repeat (3) cycle();

    // Single source, 40 words: 16 / 16 / 8
    do_reset();
    load(0, 40);
    repeat (60) cycle();
    chk("t34_log_n", 64'(log_n), 64'd3);
    chk_log("t34_g0", 0, 0, 16);
    chk_log("t34_g1", 1, 0, 16);
    chk_log("t34_g2", 2, 0, 8);
    chk("t34_tcnt", 64'(TRANSFER_CNT), 64'd40);

    // Four sources, 20 words each
    do_reset();
    for (int s = 0; s < N; s++) load(s, 20);
    repeat (110) cycle();
    chk("t35_log_n", 64'(log_n), 64'd8);
    for (int i = 0; i < 8; i++) chk_log("t35_g", i, exp35_s[i], exp35_w[i]);
    chk("t35_tcnt", 64'(TRANSFER_CNT), 64'd80);

    // Source 1 with READY toggling every cycle
    do_reset();
    load(1, 20);
    for (int i = 0; i < 60; i++) begin
      rdy_v = (i % 2 == 0);
      cycle();
    end
    rdy_v = 1'b1;
    repeat (10) cycle();
    chk_log("t36_g0", 0, 1, 16);
    chk_log("t36_g1", 1, 1, 4);
    chk("t36_tcnt", 64'(TRANSFER_CNT), 64'd20);

    // ENABLE[2] dropped after 5 words
    do_reset();
    load(2, 20);
    load(3, 10);
    w = 0;
    while (popped[2] < 5 && w < 40) begin
      cycle();
      w++;
    end
    chk("t37_wait_src2", 64'(popped[2]), 64'd5);
    en_v[2] = 1'b0;
    repeat (30) cycle();
    chk("t37_log_n", 64'(log_n), 64'd2);
    chk_log("t37_g0", 0, 2, 5);
    chk_log("t37_g1", 1, 3, 10);
    chk("t37_src2_left", 64'(popped[2]), 64'd5);
    en_v = '1;

    // Reset mid-burst after 7 words of source 3
    do_reset();
    load(3, 20);
    w = 0;
    while (popped[3] < 7 && w < 40) begin
      cycle();
      w++;
    end
    chk("t38_wait_src3", 64'(popped[3]), 64'd7);
    rst_v = 1'b1;
    load(0, 3);
    cycle();
    rst_v = 1'b0;
    log_n = 0;
    chk("t38_tcnt_restart", 64'(TRANSFER_CNT), 64'd0);
    chk("t38_no_pop_in_rst", 64'(popped[3]), 64'd7);
    repeat (40) cycle();
    chk_log("t38_g0", 0, 0, 3);
    chk_log("t38_g1", 1, 3, 13);
    chk("t38_tcnt", 64'(TRANSFER_CNT), 64'd16);

    // TRANSFER_CNT wrap
    do_reset();
    force dut.tcnt_q = 32'hFFFF_FFFF;
    m_tcnt = 32'hFFFF_FFFF;
    cycle();
    release dut.tcnt_q;
    load(1, 2);
    repeat (10) cycle();
    chk("t39_wrap", 64'(TRANSFER_CNT), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
